// File: rtl/int_source_conditioner.sv
// -----------------------------------------------------------------------------
// int_source_conditioner
//   Front end for the CP0 interrupt inputs. Each raw, asynchronous, bouncy
//   request line is synchronised, debounced and edge-detected. Every accepted
//   rising edge produces a fixed-width pulse on intsrc[]. After each pulse there
//   is a hold-off window. Any enabled edge that arrives while the line is busy
//   is recorded in the sticky dropped[] register.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active-low
//   raw_in       raw request lines, active-high, asynchronous
//   src_mask     1 = line enabled, 0 = debounced edges ignored
//   clr_dropped  per-line synchronous clear of dropped[]
//   intsrc       clean interrupt pulses to CP0
//   busy         line is in PULSE or HOLDOFF
//   dropped      sticky: enabled edge arrived while busy
//   db_level     debounced level (status readback)
// -----------------------------------------------------------------------------
module int_source_conditioner #(
   parameter int unsigned N_SRC          = 3,
   parameter int unsigned DB_CYCLES      = 16,
   parameter int unsigned PULSE_CYCLES   = 2,
   parameter int unsigned HOLDOFF_CYCLES = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] raw_in,
   input  logic [N_SRC-1:0] src_mask,
   input  logic [N_SRC-1:0] clr_dropped,
   output logic [N_SRC-1:0] intsrc,
   output logic [N_SRC-1:0] busy,
   output logic [N_SRC-1:0] dropped,
   output logic [N_SRC-1:0] db_level
);

   localparam int unsigned CW = $clog2(DB_CYCLES) + 1;
   localparam int unsigned PW = $clog2(PULSE_CYCLES) + 1;
   localparam int unsigned HW = $clog2((HOLDOFF_CYCLES > 1) ? HOLDOFF_CYCLES : 1) + 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PULSE   = 2'd1,
      HOLDOFF = 2'd2
   } state_t;

   logic [N_SRC-1:0] sync1;
   logic [N_SRC-1:0] sync2;

   // Plain two-flop synchroniser with no logic between the stages.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw_in;
         sync2 <= sync1;
      end
   end

   genvar i;
   generate
      for (i = 0; i < N_SRC; i++) begin : g_line
         logic [CW-1:0] cnt;
         logic          db_r;
         logic          db_prev;
         logic          rise;
         state_t        state;
         state_t        state_nxt;
         logic [PW-1:0] pcnt;
         logic [PW-1:0] pcnt_nxt;
         logic [HW-1:0] hcnt;
         logic [HW-1:0] hcnt_nxt;
         logic          intsrc_r;
         logic          busy_r;
         logic          dropped_r;

         // Debounce: accept a new level only after DB_CYCLES consecutive
         // disagreeing samples. Any return to the old level restarts the count.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               cnt     <= '0;
               db_r    <= 1'b0;
               db_prev <= 1'b0;
            end else begin
               db_prev <= db_r;
               if (sync2[i] == db_r) begin
                  cnt <= '0;
               end else if (cnt == CW'(DB_CYCLES - 1)) begin
                  db_r <= sync2[i];
                  cnt  <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
         end

         assign rise = db_r & ~db_prev;

         always_comb begin
            state_nxt = state;
            pcnt_nxt  = pcnt;
            hcnt_nxt  = hcnt;
            case (state)
               IDLE: begin
                  if (rise && src_mask[i]) begin
                     state_nxt = PULSE;
                     pcnt_nxt  = PW'(PULSE_CYCLES - 1);
                  end
               end
               PULSE: begin
                  if (pcnt == '0) begin
                     if (HOLDOFF_CYCLES > 0) begin
                        state_nxt = HOLDOFF;
                        hcnt_nxt  = HW'(HOLDOFF_CYCLES - 1);
                     end else begin
                        state_nxt = IDLE;
                     end
                  end else begin
                     pcnt_nxt = pcnt - 1'b1;
                  end
               end
               HOLDOFF: begin
                  if (hcnt == '0) begin
                     state_nxt = IDLE;
                  end else begin
                     hcnt_nxt = hcnt - 1'b1;
                  end
               end
               default: state_nxt = IDLE;
            endcase
         end

         // The outputs are decoded from the next state into flops. This keeps
         // them glitch-free and cycle-aligned with the state register.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               state     <= IDLE;
               pcnt      <= '0;
               hcnt      <= '0;
               intsrc_r  <= 1'b0;
               busy_r    <= 1'b0;
               dropped_r <= 1'b0;
            end else begin
               state    <= state_nxt;
               pcnt     <= pcnt_nxt;
               hcnt     <= hcnt_nxt;
               intsrc_r <= (state_nxt == PULSE);
               busy_r   <= (state_nxt != IDLE);
               // A new drop takes precedence over a clear in the same cycle.
               if (rise && src_mask[i] && busy_r) begin
                  dropped_r <= 1'b1;
               end else if (clr_dropped[i]) begin
                  dropped_r <= 1'b0;
               end
            end
         end

         assign intsrc[i]   = intsrc_r;
         assign busy[i]     = busy_r;
         assign dropped[i]  = dropped_r;
         assign db_level[i] = db_r;
      end
   endgenerate

endmodule
